// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-entry front end and its consumers.
package alu_pkg;

  // Default operand width, matching the ALU datapath.
  localparam int DEF_WIDTH = 3;

  // ALU opcode width.
  localparam int OP_W = 2;

  // Entry stage encodings. The display mux decodes these directly.
  typedef enum logic [1:0] {
    STG_A    = 2'd0,
    STG_B    = 2'd1,
    STG_OP   = 2'd2,
    STG_SHOW = 2'd3
  } stage_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, run-length debounce and
// a registered one-cycle pulse on every accepted 0->1 transition.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int DEB_W = $clog2(DEB_CYCLES);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("btn_debounce: DEB_CYCLES must be >= 2");
  end

  logic [1:0]       r_sync;
  logic             r_db;
  logic [DEB_W-1:0] r_cnt;
  logic             r_press;
  logic             w_btn_s;

  assign w_btn_s = r_sync[1];
  assign press   = r_press;

  // Synchronise the raw level; nothing else looks at btn_raw.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], btn_raw};
  end

  // Accept a new level only after DEB_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the run. The press pulse is
  // produced in the same edge as the accepted rise so the FSM acts one
  // edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (w_btn_s == r_db) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      r_db    <= w_btn_s;
      r_cnt   <= '0;
      r_press <= w_btn_s;
    end else begin
      r_cnt   <= r_cnt + DEB_W'(1);
      r_press <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_entry.sv
// Operator entry front end: debounced button steps A -> B -> OP -> SHOW,
// latching the synchronised switches into in1, in2 and op, and pulses
// valid once when a complete operand set has been entered.
module alu_operand_entry
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [OP_W-1:0]  op,
  output logic             valid,
  output logic [1:0]       stage
);

  if (WIDTH < 2) begin : g_bad_width
    $error("alu_operand_entry: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] r_sw_m;
  logic [WIDTH-1:0] r_sw_s;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [OP_W-1:0]  r_op;
  logic             r_valid;
  stage_e           r_stage;
  stage_e           w_stage_nxt;
  logic             w_press;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .press   (w_press)
  );

  // Switches are only synchronised; bounce is harmless because they are
  // sampled once, in the press cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_m <= '0;
      r_sw_s <= '0;
    end else begin
      r_sw_m <= sw_raw;
      r_sw_s <= r_sw_m;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    if (rst) r_stage <= STG_A;
    else     r_stage <= w_stage_nxt;
  end

  // Next stage: advance one step per press, otherwise hold.
  always_comb begin
    w_stage_nxt = r_stage;
    if (w_press) begin
      case (r_stage)
        STG_A:    w_stage_nxt = STG_B;
        STG_B:    w_stage_nxt = STG_OP;
        STG_OP:   w_stage_nxt = STG_SHOW;
        STG_SHOW: w_stage_nxt = STG_A;
        default:  w_stage_nxt = STG_A;
      endcase
    end
  end

  // Operand/opcode loads; values persist until overwritten or reset, so
  // the ALU sees partial updates and only valid marks a coherent set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_op  <= '0;
    end else if (w_press) begin
      case (r_stage)
        STG_A:   r_in1 <= r_sw_s;
        STG_B:   r_in2 <= r_sw_s;
        STG_OP:  r_op  <= r_sw_s[OP_W-1:0];
        default: ;
      endcase
    end
  end

  // valid is high only in the first SHOW cycle of each pass.
  always_ff @(posedge clk) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= w_press && (r_stage == STG_OP);
  end

  assign in1   = r_in1;
  assign in2   = r_in2;
  assign op    = r_op;
  assign valid = r_valid;
  assign stage = r_stage;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry: directed button/switch sequences, a
// cycle-level reference model checked every cycle, plus literal checks.
module tb_alu_operand_entry;

  localparam int W   = 3;
  localparam int DEB = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_raw = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] in1, in2;
  logic [1:0]   op;
  logic         valid;
  logic [1:0]   stage;

  int vectors = 0;
  int errors  = 0;
  int vcnt    = 0;

  alu_operand_entry #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .sw_raw  (sw_raw),
    .in1     (in1),
    .in2     (in2),
    .op      (op),
    .valid   (valid),
    .stage   (stage)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button: the synchronised level is the raw level two edges late; the
  // accepted level flips when the last DEB synchronised samples all
  // disagree with it. A rise yields a press seen in the next cycle, and
  // each press advances the entry sequence using the switches seen then.
  bit           rawq[$];
  bit           bsq[$];
  logic [W-1:0] swq[$];
  bit           m_init = 0;
  bit           m_db, m_press, m_valid;
  int           m_stage;
  logic [W-1:0] m_in1, m_in2, sws;
  logic [1:0]   m_op;

  always @(posedge clk) begin
    if (rst) begin
      rawq.delete(); bsq.delete(); swq.delete();
      m_db = 0; m_press = 0; m_valid = 0; m_stage = 0;
      m_in1 = '0; m_in2 = '0; m_op = '0;
      m_init = 1;
    end else begin
      bit bs, all_diff;
      bs  = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 1'b0;
      sws = (swq.size() >= 2) ? swq[swq.size()-2] : '0;
      m_valid = 0;
      if (m_press) begin
        if (m_stage == 0) m_in1 = sws;
        else if (m_stage == 1) m_in2 = sws;
        else if (m_stage == 2) begin m_op = sws[1:0]; m_valid = 1; end
        m_stage = (m_stage + 1) % 4;
      end
      bsq.push_back(bs);
      if (bsq.size() > DEB) void'(bsq.pop_front());
      all_diff = (bsq.size() == DEB);
      foreach (bsq[i]) if (bsq[i] == m_db) all_diff = 0;
      m_press = all_diff && !m_db;
      if (all_diff) m_db = !m_db;
      rawq.push_back(btn_raw);
      swq.push_back(sw_raw);
      if (rawq.size() > 4) void'(rawq.pop_front());
      if (swq.size() > 4) void'(swq.pop_front());
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      cmp("m_in1",   int'(in1),   int'(m_in1));
      cmp("m_in2",   int'(in2),   int'(m_in2));
      cmp("m_op",    int'(op),    int'(m_op));
      cmp("m_valid", int'(valid), int'(m_valid));
      cmp("m_stage", int'(stage), m_stage);
      if (valid === 1'b1) vcnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  // Full clean press: set switches, hold well past debounce, release.
  task automatic press(input logic [W-1:0] v);
    sw_raw = v;
    tick(5);
    btn_raw = 1'b1;
    tick(40);
    btn_raw = 1'b0;
    tick(30);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, then a single clean press with sw=5
    sw_raw = 3'b101;
    do_reset(3);
    tick(5);
    cmp("rst_stage", int'(stage), 0);
    cmp("rst_in1",   int'(in1),   0);
    cmp("rst_valid", int'(valid), 0);
    btn_raw = 1'b1;
    tick(DEB + 2);
    cmp("t1_pre_stage", int'(stage), 0);
    cmp("t1_pre_in1",   int'(in1),   0);
    tick(1);
    cmp("t1_stage", int'(stage), 1);
    cmp("t1_in1",   int'(in1),   5);
    cmp("t1_valid", int'(valid), 0);
    tick(20);
    btn_raw = 1'b0;
    tick(30);

    // 2: full pass 2, 6, 3 and a fourth press back to A
    do_reset(2);
    tick(3);
    vcnt = 0;
    press(3'd2);
    cmp("t2_in1", int'(in1), 2);
    press(3'd6);
    cmp("t2_in2", int'(in2), 6);
    sw_raw = 3'b011;
    tick(5);
    btn_raw = 1'b1;
    tick(DEB + 3);
    cmp("t2_show_stage", int'(stage), 3);
    cmp("t2_show_valid", int'(valid), 1);
    cmp("t2_op",         int'(op),    3);
    tick(1);
    cmp("t2_valid_drop", int'(valid), 0);
    tick(20);
    btn_raw = 1'b0;
    tick(30);
    cmp("t2_vcnt", vcnt, 1);
    press(3'd0);
    cmp("t2_wrap_stage", int'(stage), 0);
    cmp("t2_keep_in1",   int'(in1),   2);

    // 3: 15-cycle glitch is ignored; bouncy press gives exactly one step
    btn_raw = 1'b1;
    tick(DEB - 1);
    btn_raw = 1'b0;
    tick(30);
    cmp("t3_glitch_stage", int'(stage), 0);
    sw_raw = 3'd3;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      btn_raw = 1'b1; tick(5);
      btn_raw = 1'b0; tick(3);
    end
    btn_raw = 1'b1;
    tick(40);
    btn_raw = 1'b0;
    tick(30);
    cmp("t3_bounce_stage", int'(stage), 1);
    cmp("t3_bounce_in1",   int'(in1),   3);

    // 4: long hold with switches changing mid-hold loads once
    sw_raw = 3'd1;
    tick(5);
    btn_raw = 1'b1;
    tick(100);
    sw_raw = 3'd7;
    tick(100);
    btn_raw = 1'b0;
    tick(30);
    cmp("t4_in2",   int'(in2),   1);
    cmp("t4_stage", int'(stage), 2);

    // 5: reset in OP with in1=4, in2=1; button held across reset
    do_reset(2);
    tick(3);
    press(3'd4);
    press(3'd1);
    cmp("t5_pre_stage", int'(stage), 2);
    cmp("t5_pre_in1",   int'(in1),   4);
    sw_raw = 3'd6;
    btn_raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    cmp("t5_rst_in1",   int'(in1),   0);
    cmp("t5_rst_in2",   int'(in2),   0);
    cmp("t5_rst_op",    int'(op),    0);
    cmp("t5_rst_valid", int'(valid), 0);
    cmp("t5_rst_stage", int'(stage), 0);
    tick(2);
    rst = 1'b0;
    tick(DEB + 2);
    cmp("t5_held_pre", int'(stage), 0);
    tick(1);
    cmp("t5_held_stage", int'(stage), 1);
    cmp("t5_held_in1",   int'(in1),   6);
    tick(40);
    btn_raw = 1'b0;
    tick(30);
    cmp("t5_one_press", int'(stage), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
